map_column_feeder: RTL

Streams the level map out of a synchronous map ROM into the game datapath, one 100-bit wall column per shift. Sits directly upstream of the datapath's wall shifter and replaces its hard-coded next-wall value. Assembles each column from four 25-bit ROM words, buffers up to two finished columns, and flags the final column of the map.

---
 rtl/josh_pkg.sv | 16 +
 rtl/col_fifo2.sv | 53 +++++
 rtl/map_column_feeder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/josh_pkg.sv
// Shared constants and state encoding for the map streaming blocks.
package josh_pkg;

    localparam int COL_BITS      = 100;
    localparam int WORD_BITS     = 25;
    localparam int WORDS_PER_COL = 4;
    localparam int MAP_COLS      = 512;
    localparam int ADDR_W        = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/col_fifo2.sv
// Two-entry column buffer; the head entry is read combinationally from the read pointer.
module col_fifo2 #(
    parameter int WIDTH = 101
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = mem[rd_ptr];

    // Pointer/occupancy bookkeeping and storage; flush drops everything at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/map_column_feeder.sv
// Streams wall columns out of the map ROM: four ROM words per column are
// assembled, buffered two deep, and handed to the wall shifter on demand.
module map_column_feeder #(
    parameter int COL_BITS      = josh_pkg::COL_BITS,
    parameter int WORD_BITS     = josh_pkg::WORD_BITS,
    parameter int WORDS_PER_COL = josh_pkg::WORDS_PER_COL,
    parameter int MAP_COLS      = josh_pkg::MAP_COLS,
    parameter int ADDR_W        = josh_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 flush,
    output logic                 rom_rd,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [WORD_BITS-1:0] rom_data,
    output logic                 col_valid,
    input  logic                 col_ready,
    output logic [COL_BITS-1:0]  col_data,
    output logic                 col_last,
    output logic                 busy,
    output logic                 map_done
);

    import josh_pkg::*;

    localparam int                WC_W      = $clog2(WORDS_PER_COL);
    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(WORDS_PER_COL - 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(MAP_COLS - 1);
    localparam int                ASM_BITS  = COL_BITS - WORD_BITS;

    feeder_state_t           state;
    feeder_state_t           state_next;
    logic [ADDR_W-1:0]       col_idx;
    logic [WC_W-1:0]         word_cnt;
    logic                    issuing;
    logic                    all_issued;
    logic                    ret_vld;
    logic                    ret_final;
    logic                    ret_last;
    logic [ASM_BITS-1:0]     asm_q;
    logic [COL_BITS-1:0]     col_next;
    logic                    clear_stream;
    logic                    can_begin;
    logic [2:0]              occupancy;
    logic                    push;
    logic                    pop;
    logic [COL_BITS:0]       fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [1:0]              fifo_count;

    // Either control pulse abandons whatever is buffered or still returning from the ROM.
    assign clear_stream = start || flush;

    // The column being assembled counts against the two buffer slots from its first issue until it lands.
    assign occupancy = {1'b0, fifo_count} + {2'b00, (issuing || ret_vld)};
    assign can_begin = (state == ST_FETCH) && !issuing && !all_issued
                       && !fifo_full && (occupancy < 3'd2);

    assign rom_rd   = (state == ST_FETCH) && (issuing || can_begin);
    assign rom_addr = rom_rd ? (col_idx * ADDR_W'(WORDS_PER_COL)) + ADDR_W'(word_cnt) : '0;

    // Each returning word enters at the top, so word 0 ends up in the lowest bits.
    assign col_next = {rom_data, asm_q};
    assign push     = ret_vld && ret_final && !clear_stream;
    assign pop      = col_valid && col_ready;

    assign col_valid = !fifo_empty && (state == ST_FETCH);
    assign col_data  = col_valid ? fifo_head[COL_BITS-1:0] : '0;
    assign col_last  = col_valid && fifo_head[COL_BITS];
    assign busy      = (state == ST_FETCH);
    assign map_done  = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: flush beats start, and the stream ends once the last-tagged column leaves.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else if (start) begin
            state_next = ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: if (pop && fifo_head[COL_BITS]) state_next = ST_DONE;
                default:  state_next = state;
            endcase
        end
    end

    // Word issue sequencing and tracking of the words still coming back from the ROM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_idx    <= '0;
            word_cnt   <= '0;
            issuing    <= 1'b0;
            all_issued <= 1'b0;
            ret_vld    <= 1'b0;
            ret_final  <= 1'b0;
            ret_last   <= 1'b0;
        end else if (clear_stream) begin
            col_idx    <= '0;
            word_cnt   <= '0;
            issuing    <= 1'b0;
            all_issued <= 1'b0;
            ret_vld    <= 1'b0;
            ret_final  <= 1'b0;
            ret_last   <= 1'b0;
        end else begin
            ret_vld   <= rom_rd;
            ret_final <= rom_rd && (word_cnt == LAST_WORD);
            ret_last  <= (col_idx == LAST_COL);
            if (rom_rd) begin
                if (word_cnt == LAST_WORD) begin
                    word_cnt <= '0;
                    issuing  <= 1'b0;
                    if (col_idx == LAST_COL) begin
                        all_issued <= 1'b1;
                    end else begin
                        col_idx <= col_idx + 1'b1;
                    end
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    issuing  <= 1'b1;
                end
            end
        end
    end

    // Assembly shift register holding the words of the column in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            asm_q <= '0;
        end else if (clear_stream) begin
            asm_q <= '0;
        end else if (ret_vld) begin
            asm_q <= col_next[COL_BITS-1:WORD_BITS];
        end
    end

    col_fifo2 #(
        .WIDTH (COL_BITS + 1)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .flush   (clear_stream),
        .wr_data ({ret_last, col_next}),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule
